// File: rtl/toeplitz_seed_hash.sv
// Toeplitz GF(2) hash: captures a seed over the shift_en/shift_ack handshake, folds IN_W serial bits into an OUT_W hash.
// Optional macro SEED_REUSE_EN: keep the captured seed and rerun blocks on it without a new handshake.
module toeplitz_seed_hash #(
  parameter int SEED_W = 7168,
  parameter int IN_W   = 6144,
  parameter int OUT_W  = 1024
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              shift_en,
  input  logic [SEED_W-1:0] seed,
  output logic              shift_ack,
  input  logic              din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [OUT_W-1:0]  hash_out,
  output logic              hash_valid,
  input  logic              hash_ready
);

  localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(IN_W - 1);

  typedef enum logic [1:0] {IDLE, ACK, HASH, DONE} state_t;

  state_t             state_q, state_d;
  logic [SEED_W-1:0]  seed_reg_q, seed_reg_d;
  logic [OUT_W-1:0]   acc_q, acc_d;
  logic [OUT_W-1:0]   hash_out_q, hash_out_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               armed_q, armed_d;
  logic [OUT_W-1:0]   term;
`ifdef SEED_REUSE_EN
  logic [SEED_W-1:0]  seed_base_q, seed_base_d;
`endif

  // Row j of the Toeplitz matrix is the seed window starting at bit j; shifting seed_reg walks it.
  assign term = din ? seed_reg_q[OUT_W-1:0] : '0;

  always_comb begin
    state_d    = state_q;
    seed_reg_d = seed_reg_q;
    acc_d      = acc_q;
    hash_out_d = hash_out_q;
    bit_cnt_d  = bit_cnt_q;
    // Re-arm on any low cycle so a seed held across a whole block is taken only once.
    armed_d    = shift_en ? armed_q : 1'b1;
`ifdef SEED_REUSE_EN
    seed_base_d = seed_base_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (shift_en && armed_q) begin
          seed_reg_d = seed;
          acc_d      = '0;
          bit_cnt_d  = '0;
          armed_d    = 1'b0;
`ifdef SEED_REUSE_EN
          seed_base_d = seed;
`endif
          state_d    = ACK;
        end
      end
      ACK: state_d = HASH;
      HASH: begin
        if (din_valid) begin
          acc_d      = acc_q ^ term;
          seed_reg_d = seed_reg_q >> 1;
          bit_cnt_d  = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == LAST_IDX) begin
            hash_out_d = acc_q ^ term;
            state_d    = DONE;
          end
        end
      end
      DONE: begin
        if (hash_ready) begin
`ifdef SEED_REUSE_EN
          // A waiting new seed wins; otherwise rerun on the stored one.
          if (!(shift_en && armed_q)) begin
            seed_reg_d = seed_base_q;
            acc_d      = '0;
            bit_cnt_d  = '0;
            state_d    = HASH;
          end else begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      seed_reg_q <= '0;
      acc_q      <= '0;
      hash_out_q <= '0;
      bit_cnt_q  <= '0;
      armed_q    <= 1'b1;
`ifdef SEED_REUSE_EN
      seed_base_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      seed_reg_q <= seed_reg_d;
      acc_q      <= acc_d;
      hash_out_q <= hash_out_d;
      bit_cnt_q  <= bit_cnt_d;
      armed_q    <= armed_d;
`ifdef SEED_REUSE_EN
      seed_base_q <= seed_base_d;
`endif
    end
  end

  assign shift_ack  = (state_q == ACK);
  assign din_ready  = (state_q == HASH);
  assign hash_valid = (state_q == DONE);
  assign hash_out   = hash_out_q;

endmodule

// File: tb/tb_toeplitz_seed_hash.sv
// Scoreboard bench for toeplitz_seed_hash: directed seed/hash cases plus random blocks against a GF(2) window-XOR model.
module tb_toeplitz_seed_hash;
  localparam int SEED_W = 16;
  localparam int IN_W   = 8;
  localparam int OUT_W  = 8;

  logic              clk_in = 1'b0;
  logic              rst, shift_en, din, din_valid, hash_ready;
  logic [SEED_W-1:0] seed;
  logic              shift_ack, din_ready, hash_valid;
  logic [OUT_W-1:0]  hash_out;

  always #5 clk_in = ~clk_in;

  toeplitz_seed_hash #(.SEED_W(SEED_W), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk_in(clk_in), .rst(rst), .shift_en(shift_en), .seed(seed), .shift_ack(shift_ack),
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .hash_out(hash_out), .hash_valid(hash_valid), .hash_ready(hash_ready)
  );

  int checks = 0, failures = 0, ack_cnt = 0;
  logic [OUT_W-1:0] exp_q[$];
  logic             prev_hold = 1'b0;
  logic [OUT_W-1:0] prev_hash = '0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Hash = XOR of the OUT_W-bit seed windows starting at every set input bit.
  function automatic logic [OUT_W-1:0] model(input logic [SEED_W-1:0] s, input logic [IN_W-1:0] b);
    logic [OUT_W-1:0] h = '0;
    for (int j = 0; j < IN_W; j++)
      if (b[j]) h = h ^ OUT_W'(s >> j);
    return h;
  endfunction

  // Monitor: counts ack pulses, checks hold stability and pops the scoreboard on accept.
  always @(negedge clk_in) begin
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (shift_ack) ack_cnt++;
      if (hash_valid) begin
        if (prev_hold) chk("hash_stable", 32'(hash_out), 32'(prev_hash));
        if (hash_ready) begin
          if (exp_q.size() > 0) begin
            chk("hash_out", 32'(hash_out), 32'(exp_q.pop_front()));
          end else begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty: got hash %0h expected none", hash_out);
          end
          prev_hold = 1'b0;
        end else begin
          prev_hold = 1'b1;
          prev_hash = hash_out;
        end
      end else begin
        prev_hold = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!din_ready && n < 20) begin
      tick();
      n++;
    end
    chk("din_ready_wait", 32'(din_ready), 32'd1);
  endtask

  // mode 0: back-to-back, 1: valid toggles every cycle, 2: random gaps
  task automatic feed(input logic [IN_W-1:0] bits, input int mode, input int nbits);
    for (int j = 0; j < nbits; j++) begin
      int gaps = (mode == 1 && j > 0) ? 1 : (mode == 2 ? int'($urandom_range(0, 2)) : 0);
      for (int g = 0; g < gaps; g++) begin
        din_valid = 1'b0;
        din = 1'($urandom_range(0, 1));
        chk("din_ready_gap", 32'(din_ready), 32'd1);
        tick();
      end
      din_valid = 1'b1;
      din = bits[j];
      chk("din_ready_bit", 32'(din_ready), 32'd1);
      tick();
    end
    din_valid = 1'b0;
    din = 1'b0;
  endtask

  task automatic run_block(input logic [IN_W-1:0] bits, input logic [OUT_W-1:0] exp, input int mode,
                           input int dly, input logic [SEED_W-1:0] next_seed, input bit reload);
    int a0, n;
    wait_ready();
    feed(bits, mode, IN_W);
    exp_q.push_back(exp);
    chk("hash_valid_latency", 32'(hash_valid), 32'd1);
    chk("din_ready_done", 32'(din_ready), 32'd0);
    a0 = ack_cnt;
    if (reload) begin
      shift_en = 1'b1;
      seed = next_seed;
    end
    repeat (dly) tick();
    chk("hash_valid_held", 32'(hash_valid), 32'd1);
    chk("no_ack_in_done", 32'(ack_cnt), 32'(a0));
    hash_ready = 1'b1;
    tick();
    hash_ready = 1'b0;
    chk("hash_valid_clear", 32'(hash_valid), 32'd0);
    if (reload) begin
      n = 0;
      while (ack_cnt == a0 && n < 10) begin
        tick();
        n++;
      end
      chk("reload_ack", 32'(ack_cnt), 32'(a0 + 1));
      shift_en = 1'b0;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [SEED_W-1:0] cur, nxt;
    logic [IN_W-1:0]   bits;
    int a0;
    rst = 1'b1; shift_en = 1'b0; seed = '0; din = 1'b0; din_valid = 1'b0; hash_ready = 1'b0;
    tick();
    tick();
    chk("rst_shift_ack", 32'(shift_ack), 32'd0);
    chk("rst_din_ready", 32'(din_ready), 32'd0);
    chk("rst_hash_valid", 32'(hash_valid), 32'd0);
    chk("rst_hash_out", 32'(hash_out), 32'd0);
    rst = 1'b0;
    tick();

    // Seed held three cycles: one ack, one cycle after capture, no recapture.
    cur = 16'hA5C3;
    a0 = ack_cnt;
    shift_en = 1'b1;
    seed = cur;
    tick();
    chk("ack_pulse", 32'(shift_ack), 32'd1);
    chk("din_ready_in_ack", 32'(din_ready), 32'd0);
    tick();
    chk("ack_one_cycle", 32'(shift_ack), 32'd0);
    chk("din_ready_in_hash", 32'(din_ready), 32'd1);
    tick();
    shift_en = 1'b0;
    tick();
    tick();
    chk("ack_count_held", 32'(ack_cnt), 32'(a0 + 1));

    run_block(8'h01, 8'hC3, 0, 5, cur, 1'b1);
    run_block(8'h03, 8'h22, 0, 0, cur, 1'b1);
    run_block(8'h01, 8'hC3, 1, 1, cur, 1'b1);
    run_block(8'h80, 8'h4B, 0, 0, cur, 1'b1);
    nxt = SEED_W'($urandom);
    run_block(8'h00, 8'h00, 2, 0, nxt, 1'b1);
    cur = nxt;
    for (int i = 0; i < 16; i++) begin
      bits = IN_W'($urandom);
      nxt = SEED_W'($urandom);
      run_block(bits, model(cur, bits), 2, int'($urandom_range(0, 3)), nxt, 1'b1);
      cur = nxt;
    end

    // Reset in the middle of a block: nothing emitted, fresh ack afterwards.
    wait_ready();
    feed(8'hFF, 0, 4);
    a0 = ack_cnt;
    rst = 1'b1;
    #1;
    chk("midrst_shift_ack", 32'(shift_ack), 32'd0);
    chk("midrst_din_ready", 32'(din_ready), 32'd0);
    chk("midrst_hash_valid", 32'(hash_valid), 32'd0);
    chk("midrst_hash_out", 32'(hash_out), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    chk("midrst_idle", 32'(din_ready), 32'd0);
    chk("midrst_no_ack", 32'(ack_cnt), 32'(a0));
    cur = 16'hA5C3;
    shift_en = 1'b1;
    seed = cur;
    tick();
    chk("fresh_ack", 32'(shift_ack), 32'd1);
    tick();
    shift_en = 1'b0;
    a0 = ack_cnt;
    run_block(8'h80, 8'h4B, 0, 2, '0, 1'b0);
`ifdef SEED_REUSE_EN
    run_block(8'h80, 8'h4B, 2, 0, '0, 1'b0);
    chk("reuse_no_ack", 32'(ack_cnt), 32'(a0));
`else
    tick();
    chk("idle_after_accept", 32'(din_ready), 32'd0);
    chk("no_ack_without_seed", 32'(ack_cnt), 32'(a0));
`endif
    repeat (3) tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
